// File: rtl/i2c_seq_engine.sv
// i2c_seq_engine: walks WRITE/READ/DELAY/END entries from a synchronous ROM
// and drives an I2C master through its request/done handshake. It also
// handles NACK retry, read-data capture, abort and run error reporting.
module i2c_seq_engine #(
  parameter int REG_W      = 16,
  parameter int DATA_W     = 16,
  parameter int ROM_AW     = 12,
  parameter int MAX_STEPS  = 2048,
  parameter int MAX_RETRY  = 3,
  parameter int DELAY_UNIT = 1000,
  parameter int ENTRY_W    = 9 + REG_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ROM_AW-1:0]  list_base,
  input  logic               abort,
  output logic [ROM_AW-1:0]  rom_addr,
  output logic               rom_en,
  input  logic [ENTRY_W-1:0] rom_q,
  output logic               i2c_rqt,
  output logic               cmd,
  output logic [6:0]         addr_dev,
  output logic [REG_W-1:0]   addr_reg,
  output logic [DATA_W-1:0]  data_wr,
  input  logic               i2c_done,
  input  logic               i2c_nack,
  input  logic [DATA_W-1:0]  data_rd,
  output logic               rd_valid,
  output logic [REG_W-1:0]   rd_reg,
  output logic [DATA_W-1:0]  rd_data,
  output logic               busy,
  output logic               config_done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [11:0]        step_number
);

  localparam int CNT_W = DATA_W + $clog2(DELAY_UNIT + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  localparam int STP_W = $clog2(MAX_STEPS + 1);

  typedef enum logic [1:0] {OP_WRITE = 2'd0, OP_READ = 2'd1, OP_DELAY = 2'd2, OP_END = 2'd3} op_e;
  typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_NACK = 2'd1, ERR_STEPS = 2'd2, ERR_WRAP = 2'd3} err_e;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_REQ, S_WAIT, S_RETRY, S_DELAY, S_DONE, S_ERR
  } state_e;

  state_e             state_q, state_d;
  op_e                op_q;
  logic [ROM_AW-1:0]  ptr_q;
  logic [STP_W-1:0]   step_cnt_q;
  logic [STP_W-1:0]   step_inc;
  logic [RTY_W-1:0]   retry_q;
  logic [CNT_W-1:0]   cnt_q;

  // ROM word fields
  op_e                rom_op;
  logic [6:0]         rom_dev;
  logic [REG_W-1:0]   rom_reg;
  logic [DATA_W-1:0]  rom_data;

  // control strobes from the FSM to the datapath
  logic accept, latch, do_next, step_adv, ptr_adv, capture, retry_inc, cnt_load;
  err_e code_d;

  // outcome of the end-of-entry step: continue, or stop with an error
  state_e nxt_state;
  err_e   nxt_code;
  logic   nxt_ptr_adv;

  assign rom_op   = op_e'(rom_q[ENTRY_W-1 -: 2]);
  assign rom_dev  = rom_q[ENTRY_W-3 -: 7];
  assign rom_reg  = rom_q[DATA_W +: REG_W];
  assign rom_data = rom_q[DATA_W-1:0];
  assign rom_addr = ptr_q;
  assign step_inc = step_cnt_q + STP_W'(1);

  // decide where a completed entry leads: overrun first, then address wrap
  always_comb begin
    nxt_state   = S_FETCH;
    nxt_code    = ERR_NONE;
    nxt_ptr_adv = 1'b1;
    if (step_inc == STP_W'(MAX_STEPS)) begin
      nxt_state   = S_ERR;
      nxt_code    = ERR_STEPS;
      nxt_ptr_adv = 1'b0;
    end else if (&ptr_q) begin
      nxt_state   = S_ERR;
      nxt_code    = ERR_WRAP;
      nxt_ptr_adv = 1'b0;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic, handshake outputs and datapath strobes
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    rom_en      = 1'b0;
    i2c_rqt     = 1'b0;
    busy        = 1'b1;
    config_done = 1'b0;
    accept      = 1'b0;
    latch       = 1'b0;
    do_next     = 1'b0;
    step_adv    = 1'b0;
    ptr_adv     = 1'b0;
    capture     = 1'b0;
    retry_inc   = 1'b0;
    cnt_load    = 1'b0;
    code_d      = ERR_NONE;

    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        rom_en  = 1'b1;
        state_d = abort ? S_IDLE : S_DECODE;
      end
      S_DECODE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          latch = 1'b1;
          case (rom_op)
            OP_WRITE, OP_READ: state_d = S_REQ;
            OP_DELAY: begin
              cnt_load = 1'b1;
              if (rom_data == '0) do_next = 1'b1;
              else                state_d = S_DELAY;
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_REQ: begin
        i2c_rqt = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // request is held until the master completes, even under abort
        i2c_rqt = 1'b1;
        if (i2c_done) begin
          if (!i2c_nack) begin
            capture = (op_q == OP_READ);
            if (abort) begin
              step_adv = 1'b1;
              state_d  = S_IDLE;
            end else begin
              do_next = 1'b1;
            end
          end else if (abort) begin
            state_d = S_IDLE;
          end else if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_inc = 1'b1;
            state_d   = S_RETRY;
          end else begin
            code_d  = ERR_NACK;
            state_d = S_ERR;
          end
        end
      end
      S_RETRY: state_d = S_REQ;  // one-cycle request gap before re-attempt
      S_DELAY: begin
        if (abort)                     state_d = S_IDLE;
        else if (cnt_q == CNT_W'(1))   do_next = 1'b1;
      end
      S_DONE: begin
        busy        = 1'b0;
        config_done = 1'b1;
        state_d     = S_IDLE;
      end
      S_ERR: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (do_next) begin
      step_adv = 1'b1;
      ptr_adv  = nxt_ptr_adv;
      code_d   = nxt_code;
      state_d  = nxt_state;
    end
  end

  // datapath: pointer, counters, latched entry fields, read capture, status
  always_ff @(posedge clk) begin
    // NOTE: every register here is reset, since all outputs must read
    // zero after reset; there is no storage array that could skip it.
    if (!rst_n) begin
      ptr_q       <= '0;
      step_cnt_q  <= '0;
      step_number <= '0;
      retry_q     <= '0;
      cnt_q       <= '0;
      op_q        <= OP_WRITE;
      cmd         <= 1'b0;
      addr_dev    <= '0;
      addr_reg    <= '0;
      data_wr     <= '0;
      rd_valid    <= 1'b0;
      rd_reg      <= '0;
      rd_data     <= '0;
      error       <= 1'b0;
      err_code    <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (accept) begin
        ptr_q       <= list_base;
        step_cnt_q  <= '0;
        step_number <= '0;
        error       <= 1'b0;
        err_code    <= '0;
      end
      if (ptr_adv) ptr_q <= ptr_q + ROM_AW'(1);
      if (step_adv) begin
        step_cnt_q <= step_inc;
        if (step_number != 12'hFFF) step_number <= step_number + 12'd1;
      end
      if (latch) begin
        op_q     <= rom_op;
        cmd      <= (rom_op == OP_WRITE);
        addr_dev <= rom_dev;
        addr_reg <= rom_reg;
        data_wr  <= rom_data;
        retry_q  <= '0;
      end
      if (retry_inc) retry_q <= retry_q + RTY_W'(1);
      if (cnt_load)                  cnt_q <= CNT_W'(rom_data) * CNT_W'(DELAY_UNIT);
      else if (state_q == S_DELAY)   cnt_q <= cnt_q - CNT_W'(1);
      if (capture) begin
        rd_valid <= 1'b1;
        rd_reg   <= addr_reg;
        rd_data  <= data_rd;
      end
      if (code_d != ERR_NONE) err_code <= code_d;
      if (state_q == S_ERR)   error    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_seq_engine.sv
// Directed testbench for i2c_seq_engine with a small ROM model and a
// hand-driven I2C master.
module tb_i2c_seq_engine;

  localparam int REG_W = 16, DATA_W = 16, ROM_AW = 4, EW = 9 + REG_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n, start, abort;
  logic [ROM_AW-1:0] list_base, rom_addr;
  logic              rom_en;
  logic [EW-1:0]     rom_q = '0;
  logic              i2c_rqt, cmd, i2c_done, i2c_nack;
  logic [6:0]        addr_dev;
  logic [REG_W-1:0]  addr_reg, rd_reg;
  logic [DATA_W-1:0] data_wr, data_rd, rd_data;
  logic              rd_valid, busy, config_done, error;
  logic [1:0]        err_code;
  logic [11:0]       step_number;

  i2c_seq_engine #(
    .REG_W(REG_W), .DATA_W(DATA_W), .ROM_AW(ROM_AW),
    .MAX_STEPS(4), .MAX_RETRY(3), .DELAY_UNIT(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .list_base(list_base), .abort(abort),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_q(rom_q),
    .i2c_rqt(i2c_rqt), .cmd(cmd), .addr_dev(addr_dev), .addr_reg(addr_reg),
    .data_wr(data_wr), .i2c_done(i2c_done), .i2c_nack(i2c_nack), .data_rd(data_rd),
    .rd_valid(rd_valid), .rd_reg(rd_reg), .rd_data(rd_data), .busy(busy),
    .config_done(config_done), .error(error), .err_code(err_code),
    .step_number(step_number)
  );

  always #5 clk = ~clk;

  // synchronous ROM model: data valid the cycle after rom_en
  logic [EW-1:0] rom [16];
  always @(posedge clk) if (rom_en) rom_q <= rom[rom_addr];

  // event monitor sampled on the falling edge
  int   cyc = 0, n_rom_en = 0, n_rqt_rise = 0, n_cfg = 0;
  int   en_cyc [16];
  logic rqt_prev = 1'b0;
  always @(negedge clk) begin
    cyc      <= cyc + 1;
    rqt_prev <= i2c_rqt;
    if (rom_en) begin
      n_rom_en         <= n_rom_en + 1;
      en_cyc[rom_addr] <= cyc;
    end
    if (i2c_rqt && !rqt_prev) n_rqt_rise <= n_rqt_rise + 1;
    if (config_done)          n_cfg      <= n_cfg + 1;
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [EW-1:0] ent(input logic [1:0] op, input logic [6:0] dev,
                                        input logic [15:0] r, input logic [15:0] d);
    return {op, dev, r, d};
  endfunction

  task automatic do_start(input logic [ROM_AW-1:0] base);
    @(negedge clk);
    list_base = base;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_rqt(input string tag);
    int n = 0;
    while (i2c_rqt !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rqt_seen"}, 64'(i2c_rqt), 64'(1));
  endtask

  task automatic pulse_done(input logic nack, input logic [15:0] rdata);
    i2c_done = 1'b1;
    i2c_nack = nack;
    data_rd  = rdata;
    @(negedge clk);
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    data_rd  = '0;
  endtask

  // one master transaction: check the request fields, hold them a cycle,
  // then complete with ACK/NACK and check the request dropped
  task automatic serve(input string tag, input logic nack, input logic [15:0] rdata,
                       input logic ecmd, input logic [6:0] edev,
                       input logic [15:0] ereg, input logic [15:0] edata);
    wait_rqt(tag);
    check({tag, "_fields"}, 64'({cmd, addr_dev, addr_reg, data_wr}),
          64'({ecmd, edev, ereg, edata}));
    @(negedge clk);
    check({tag, "_fields_held"}, 64'({i2c_rqt, cmd, addr_dev, addr_reg, data_wr}),
          64'({1'b1, ecmd, edev, ereg, edata}));
    pulse_done(nack, rdata);
    check({tag, "_rqt_drop"}, 64'(i2c_rqt), 64'(0));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  int s_en, s_rqt, s_cfg;
  task automatic snap();
    s_en  = n_rom_en;
    s_rqt = n_rqt_rise;
    s_cfg = n_cfg;
  endtask

  // baseline run used both after power-up and after a mid-run reset
  task automatic basic_run(input string tag);
    snap();
    do_start(4'd0);
    check({tag, "_start_rom_en"}, 64'({rom_en, rom_addr, busy}), 64'({1'b1, 4'd0, 1'b1}));
    @(negedge clk);
    check({tag, "_decode_no_rqt"}, 64'(i2c_rqt), 64'(0));
    @(negedge clk);
    check({tag, "_req_rqt"}, 64'(i2c_rqt), 64'(1));
    serve({tag, "_wr"}, 1'b0, 16'h0, 1'b1, 7'h36, 16'h3012, 16'h0100);
    serve({tag, "_rd"}, 1'b0, 16'h00AB, 1'b0, 7'h36, 16'h4D2A, 16'h0000);
    check({tag, "_rd_capture"}, 64'({rd_valid, rd_reg, rd_data}), 64'({1'b1, 16'h4D2A, 16'h00AB}));
    @(negedge clk);
    check({tag, "_rd_valid_pulse"}, 64'(rd_valid), 64'(0));
    wait_idle(tag);
    check({tag, "_cfg_done"}, 64'(n_cfg - s_cfg), 64'(1));
    check({tag, "_rqt_count"}, 64'(n_rqt_rise - s_rqt), 64'(2));
    check({tag, "_status"}, 64'({step_number, error, err_code}), 64'({12'd2, 1'b0, 2'd0}));
  endtask

  initial begin
    rom[0]  = ent(2'd0, 7'h36, 16'h3012, 16'h0100);
    rom[1]  = ent(2'd1, 7'h36, 16'h4D2A, 16'h0000);
    rom[2]  = ent(2'd3, 7'h00, 16'h0000, 16'h0000);
    rom[3]  = ent(2'd0, 7'h10, 16'h0001, 16'h0055);
    rom[4]  = ent(2'd3, 7'h00, 16'h0000, 16'h0000);
    rom[5]  = ent(2'd2, 7'h00, 16'h0000, 16'd5);
    rom[6]  = ent(2'd2, 7'h00, 16'h0000, 16'd0);
    rom[7]  = ent(2'd3, 7'h00, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) rom[8+i] = ent(2'd0, 7'h50, 16'h0100 + 16'(i), 16'(i));
    rom[12] = ent(2'd3, 7'h00, 16'h0000, 16'h0000);
    rom[13] = ent(2'd0, 7'h22, 16'h0010, 16'h00EE);
    rom[14] = ent(2'd3, 7'h00, 16'h0000, 16'h0000);
    rom[15] = ent(2'd0, 7'h51, 16'hFFFF, 16'h1234);

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; list_base = '0;
    i2c_done = 1'b0; i2c_nack = 1'b0; data_rd = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({busy, rom_en, i2c_rqt, cmd, rd_valid, config_done, error, err_code}), 64'(0));
    check("reset_data", 64'({rom_addr, addr_dev, addr_reg, data_wr, step_number}), 64'(0));
    rst_n = 1'b1;

    // write / read / end
    basic_run("basic");

    // NACK twice then ACK: three requests, normal completion
    snap();
    do_start(4'd3);
    serve("nack2_a", 1'b1, 16'h0, 1'b1, 7'h10, 16'h0001, 16'h0055);
    serve("nack2_b", 1'b1, 16'h0, 1'b1, 7'h10, 16'h0001, 16'h0055);
    serve("nack2_c", 1'b0, 16'h0, 1'b1, 7'h10, 16'h0001, 16'h0055);
    wait_idle("nack2");
    check("nack2_rqt_count", 64'(n_rqt_rise - s_rqt), 64'(3));
    check("nack2_cfg_done", 64'(n_cfg - s_cfg), 64'(1));
    check("nack2_status", 64'({step_number, error, err_code}), 64'({12'd1, 1'b0, 2'd0}));

    // NACK four times: retries exhausted
    snap();
    do_start(4'd3);
    for (int i = 0; i < 4; i++) serve("nack4", 1'b1, 16'h0, 1'b1, 7'h10, 16'h0001, 16'h0055);
    wait_idle("nack4");
    check("nack4_err", 64'({error, err_code}), 64'({1'b1, 2'd1}));
    check("nack4_rom_en", 64'(n_rom_en - s_en), 64'(1));
    check("nack4_no_cfg", 64'(n_cfg - s_cfg), 64'(0));

    // DELAY(5) dwells 50 cycles, DELAY(0) none
    snap();
    do_start(4'd5);
    wait_idle("delay");
    check("delay5_gap", 64'(en_cyc[6] - en_cyc[5]), 64'(52));
    check("delay0_gap", 64'(en_cyc[7] - en_cyc[6]), 64'(2));
    check("delay_status", 64'({step_number, error, err_code}), 64'({12'd2, 1'b0, 2'd0}));
    check("delay_cfg", 64'(n_cfg - s_cfg), 64'(1));

    // four writes without END: step overrun
    snap();
    do_start(4'd8);
    for (int i = 0; i < 4; i++) serve("ovr", 1'b0, 16'h0, 1'b1, 7'h50, 16'h0100 + 16'(i), 16'(i));
    wait_idle("ovr");
    check("ovr_err", 64'({error, err_code, step_number}), 64'({1'b1, 2'd2, 12'd4}));
    check("ovr_rom_en", 64'(n_rom_en - s_en), 64'(4));

    // last ROM address holds a WRITE: address wrap
    do_start(4'd15);
    serve("wrap", 1'b0, 16'h0, 1'b1, 7'h51, 16'hFFFF, 16'h1234);
    wait_idle("wrap");
    check("wrap_err", 64'({error, err_code, step_number}), 64'({1'b1, 2'd3, 12'd1}));

    // abort during WAIT, plus a start while busy
    snap();
    do_start(4'd13);
    wait_rqt("abort");
    abort     = 1'b1;
    list_base = 4'd0;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_rqt_held", 64'({i2c_rqt, busy, addr_dev, addr_reg}), 64'({1'b1, 1'b1, 7'h22, 16'h0010}));
    pulse_done(1'b0, 16'h0);
    check("abort_end", 64'({i2c_rqt, busy}), 64'(0));
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_cfg_err", 64'({n_cfg - s_cfg, 1'b0, error}), 64'(0));
    check("abort_rom_en", 64'(n_rom_en - s_en), 64'(1));

    // synchronous reset mid-transaction, then a normal run
    do_start(4'd0);
    wait_rqt("rst");
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_ctrl", 64'({busy, rom_en, i2c_rqt, cmd, rd_valid, config_done, error, err_code}), 64'(0));
    check("rst_data", 64'({rom_addr, addr_dev, addr_reg, step_number}), 64'(0));
    check("rst_rd", 64'({rd_reg, rd_data}), 64'(0));
    rst_n = 1'b1;
    basic_run("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
